// File: rtl/fifo_async_fwft.sv
// Dual-clock FIFO with Gray-coded pointer crossing, optional first-word-fall-through
// read port, programmable almost-full/almost-empty thresholds and sticky error flags.
module fifo_async_fwft #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wr_af_thresh,
  input  logic                  wr_ovf_clr,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   rd_ae_thresh,
  input  logic                  rd_unf_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  ptr_t wr_ptr_q, wr_ptr_d, wr_gray_q, wr_gray_d, rd_sync_bin, wr_count_q, wr_count_d;
  logic [SYNC_STAGES-1:0][PW-1:0] rd_gray_sync_q;
  logic full_q, full_d, ovf_q, ovf_d, wr_acc;
  ptr_t rd_gray_q;

  always_comb begin
    wr_acc      = wr_en & ~full_q;
    rd_sync_bin = gray2bin(rd_gray_sync_q[SYNC_STAGES-1]);
    wr_ptr_d    = wr_ptr_q + ptr_t'(wr_acc);
    wr_gray_d   = bin2gray(wr_ptr_d);
    wr_count_d  = wr_ptr_d - rd_sync_bin;
    full_d      = (wr_count_d == ptr_t'(DEPTH));
    ovf_d       = (wr_en & full_q) | (ovf_q & ~wr_ovf_clr);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr_q       <= '0;
      wr_gray_q      <= '0;
      rd_gray_sync_q <= '0;
      wr_count_q     <= '0;
      full_q         <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      wr_gray_q      <= wr_gray_d;
      rd_gray_sync_q <= {rd_gray_sync_q[SYNC_STAGES-2:0], rd_gray_q};
      wr_count_q     <= wr_count_d;
      full_q         <= full_d;
      ovf_q          <= ovf_d;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  assign wr_count    = wr_count_q;
  assign full        = full_q;
  assign almost_full = (wr_count_q >= wr_af_thresh);
  assign overflow    = ovf_q;

  // ---------------- read domain ----------------
  // rd_ptr is the memory fetch pointer; rd_cons counts words handed to the user and
  // is what the write side sees, so prefetched words still count as occupied.
  ptr_t rd_ptr_q, rd_ptr_d, rd_cons_q, rd_cons_d, rd_gray_d, wr_sync_bin, rd_count_q, rd_count_d;
  logic [SYNC_STAGES-1:0][PW-1:0] wr_gray_sync_q;
  logic [DATA_WIDTH-1:0] mem_rd, s1_data_q, s1_data_d, out_data_q, out_data_d;
  logic s1_vld_q, s1_vld_d, out_vld_q, out_vld_d, empty_q, empty_d, unf_q, unf_d;
  logic pop, fetch, mv, unf_set;

  always_comb begin
    wr_sync_bin = gray2bin(wr_gray_sync_q[SYNC_STAGES-1]);
    mem_rd      = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    mv          = 1'b0;
    s1_vld_d    = 1'b0;
    s1_data_d   = s1_data_q;
    if (FWFT != 0) begin
      pop        = rd_en & out_vld_q;
      mv         = s1_vld_q & (~out_vld_q | pop);
      fetch      = (rd_ptr_q != wr_sync_bin) & (~s1_vld_q | mv);
      s1_vld_d   = fetch | (s1_vld_q & ~mv);
      s1_data_d  = fetch ? mem_rd : s1_data_q;
      out_vld_d  = mv | (out_vld_q & ~pop);
      out_data_d = mv ? s1_data_q : out_data_q;
      unf_set    = rd_en & ~out_vld_q;
      rd_ptr_d   = rd_ptr_q + ptr_t'(fetch);
      empty_d    = ~out_vld_d;
      rd_count_d = wr_sync_bin - rd_ptr_d + ptr_t'(s1_vld_d) + ptr_t'(out_vld_d);
    end else begin
      pop        = rd_en & ~empty_q;
      fetch      = pop;
      out_vld_d  = pop;
      out_data_d = pop ? mem_rd : out_data_q;
      unf_set    = rd_en & empty_q;
      rd_ptr_d   = rd_ptr_q + ptr_t'(fetch);
      empty_d    = (rd_ptr_d == wr_sync_bin);
      rd_count_d = wr_sync_bin - rd_ptr_d;
    end
    rd_cons_d = rd_cons_q + ptr_t'(pop);
    rd_gray_d = bin2gray(rd_cons_d);
    unf_d     = unf_set | (unf_q & ~rd_unf_clr);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_q       <= '0;
      rd_cons_q      <= '0;
      rd_gray_q      <= '0;
      wr_gray_sync_q <= '0;
      s1_vld_q       <= 1'b0;
      s1_data_q      <= '0;
      out_vld_q      <= 1'b0;
      out_data_q     <= '0;
      empty_q        <= 1'b1;
      rd_count_q     <= '0;
      unf_q          <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      rd_cons_q      <= rd_cons_d;
      rd_gray_q      <= rd_gray_d;
      wr_gray_sync_q <= {wr_gray_sync_q[SYNC_STAGES-2:0], wr_gray_q};
      s1_vld_q       <= s1_vld_d;
      s1_data_q      <= s1_data_d;
      out_vld_q      <= out_vld_d;
      out_data_q     <= out_data_d;
      empty_q        <= empty_d;
      rd_count_q     <= rd_count_d;
      unf_q          <= unf_d;
    end
  end

  assign rd_data      = out_data_q;
  assign rd_valid     = out_vld_q;
  assign rd_count     = rd_count_q;
  assign empty        = empty_q;
  assign almost_empty = (rd_count_q <= rd_ae_thresh);
  assign underflow    = unf_q;
endmodule

// File: doc/fifo_async_fwft.md
Name: fifo_async_fwft

Overview:
Parametrised dual-clock FIFO that succeeds the basic async FIFO in the shim data paths. It adds a compile-time first-word-fall-through (FWFT) or standard read mode, and a configurable synchroniser depth. It also adds run-time programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags with clears. It sits between the SPI/DAC-ADC clock domains and the AXI/PS clock domain.

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 4, memory depth = 2^ADDR_WIDTH words (ADDR_WIDTH >= 2)
SYNC_STAGES, 2, flops per Gray-pointer synchroniser (legal 2..4)
FWFT, 1, 1 = first-word-fall-through read port; 0 = standard read port with 1-cycle latency

Ports:
wr_clk  in  1  write-domain clock
wr_rst_n  in  1  asynchronous, active-low reset of the write domain
rd_clk  in  1  read-domain clock
rd_rst_n  in  1  asynchronous, active-low reset of the read domain
wr_data  in  DATA_WIDTH  write data
wr_en  in  1  write request
wr_af_thresh  in  ADDR_WIDTH+1  almost-full threshold, quasi-static
wr_ovf_clr  in  1  clears overflow
wr_count  out  ADDR_WIDTH+1  occupancy seen from the write domain
full  out  1  no write accepted this cycle
almost_full  out  1  wr_count >= wr_af_thresh
overflow  out  1  sticky: write attempted while full
rd_en  in  1  read request / pop
rd_ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static
rd_unf_clr  in  1  clears underflow
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data holds a valid word
rd_count  out  ADDR_WIDTH+1  occupancy seen from the read domain
empty  out  1  no word available to pop
almost_empty  out  1  rd_count <= rd_ae_thresh
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Pointers: binary pointers of ADDR_WIDTH+1 bits, converted to registered Gray before crossing, synchronised through SYNC_STAGES flops, and converted back to binary. All pointer arithmetic is modulo 2^(ADDR_WIDTH+1).
- Reset values, write domain (wr_rst_n low): wr pointer 0, full 0, almost_full 0 (for thresh > 0), wr_count 0, overflow 0, sync flops 0.
- Reset values, read domain (rd_rst_n low): rd pointer 0, rd_valid 0, rd_data 0, empty 1, almost_empty 1, rd_count 0, underflow 0, prefetch stages cleared.
- Reset mid-operation: both resets must overlap by at least SYNC_STAGES+1 cycles of the slower clock. Contents are discarded and no stale word appears on rd_data afterwards. Single-domain reset is unsupported.
- Write acceptance: a write is accepted when wr_en=1 and full=0; memory is written and the pointer increments at that edge.
- wr_en=1 while full=1: data is dropped, the pointer is held, and overflow sets on the next edge.
- full: asserts when wr_ptr - rd_ptr_sync == 2^ADDR_WIDTH, on the same edge as the filling write.
- wr_count = wr_ptr - rd_ptr_sync. It is conservative, overstating occupancy by in-flight reads.
- Standard mode (FWFT=0):
  - empty = (rd_ptr == wr_ptr_sync).
  - A pop is accepted when rd_en=1 and empty=0. rd_data and rd_valid=1 appear on the next rd_clk edge; rd_valid is 0 otherwise.
  - rd_count = wr_ptr_sync - rd_ptr.
- FWFT mode (FWFT=1):
  - Internal prefetch pipeline: a memory-read stage plus an output register.
  - rd_valid=1 means rd_data holds the head word, and empty = !rd_valid.
  - rd_en=1 with rd_valid=1 consumes the word. The next word, if present, is shown on the following edge, so throughput is 1 word/rd_clk with no bubbles when memory holds >= 2 words.
  - rd_count = wr_ptr_sync - rd_ptr + words held in the prefetch stages.
- Write-to-read latency:
  - Standard mode: empty deasserts SYNC_STAGES+1 to SYNC_STAGES+2 rd_clk edges after the accepting wr_clk edge.
  - FWFT mode: rd_valid asserts SYNC_STAGES+2 to SYNC_STAGES+3 rd_clk edges after the accepting wr_clk edge.
- Read-to-write latency: a freed slot is visible to full/wr_count SYNC_STAGES+1 to SYNC_STAGES+2 wr_clk edges after the pop.
- underflow: rd_en=1 while empty=1 sets underflow; pointer and data are unchanged.
- Sticky flag clears: a clear input drops its flag on the next edge. If set and clear occur in the same cycle, set wins.
- Threshold flags: almost_full and almost_empty are combinational compares of the registered counts against the thresholds. Threshold changes take effect immediately and are not synchronised.
- Pointer wrap: the occupancy after wrap-around equals the true count. The MSB toggles every 2^ADDR_WIDTH accepted operations.
- Simultaneous write and read are independent; counts converge within the sync latency.
- Memory: inferred block RAM, one write port on wr_clk and one registered read port on rd_clk.

Test Plan:
1. Defaults, FWFT=1, wr_clk 100 MHz, rd_clk 37 MHz: write 0x0001..0x0010 -> full=1 after the 16th write; overflow stays 0; rd_valid rises within 5 rd_clk edges; rd_en held high reads 0x0001..0x0010 back-to-back, after which empty=1.
2. Fill 16 words, then pulse wr_en with 0xDEAD while full -> word dropped, overflow=1; wr_ovf_clr and wr_en together with full still 1 -> overflow remains 1; later a clear alone -> overflow=0; readback shows no 0xDEAD.
3. Empty FIFO with rd_en=1 for one cycle -> underflow=1, rd_valid=0; rd_unf_clr -> underflow=0.
4. FWFT=0: write 0x00A5, then pop -> rd_valid pulses 1 cycle with rd_data=0x00A5 one rd_clk after rd_en; rd_count goes 1 -> 0.
5. wr_af_thresh=14, rd_ae_thresh=2: write 14 words -> almost_full=1 and wr_count=14; drain to 2 words -> almost_empty=1; run 100 full wrap cycles of random data -> scoreboard matches with no lost or duplicated words.
6. Assert both resets mid-stream with 9 words stored -> after release, empty=1, rd_count=0, wr_count=0, rd_valid=0; a new word 0x1234 is read first.
